// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave port among N_MASTERS masters.
// A stalled master keeps its selection, and each read's data is steered back to the master that issued it.
module naive_bus_rr_arbiter #(
    parameter int N_MASTERS = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_MASTERS-1:0]    m_rd_req,
    input  logic [4*N_MASTERS-1:0]  m_rd_be,
    input  logic [32*N_MASTERS-1:0] m_rd_addr,
    output logic [N_MASTERS-1:0]    m_rd_gnt,
    output logic [32*N_MASTERS-1:0] m_rd_data,
    input  logic [N_MASTERS-1:0]    m_wr_req,
    input  logic [4*N_MASTERS-1:0]  m_wr_be,
    input  logic [32*N_MASTERS-1:0] m_wr_addr,
    input  logic [32*N_MASTERS-1:0] m_wr_data,
    output logic [N_MASTERS-1:0]    m_wr_gnt,
    output logic                    s_rd_req,
    output logic [3:0]              s_rd_be,
    output logic [31:0]             s_rd_addr,
    input  logic                    s_rd_gnt,
    input  logic [31:0]             s_rd_data,
    output logic                    s_wr_req,
    output logic [3:0]              s_wr_be,
    output logic [31:0]             s_wr_addr,
    output logic [31:0]             s_wr_data,
    input  logic                    s_wr_gnt
);

    localparam int PW = $clog2(N_MASTERS);

    logic [PW-1:0]        rr_ptr_r;
    logic                 sel_lock_r;
    logic [PW-1:0]        sel_idx_r;
    logic                 rd_owner_vld_r;
    logic [PW-1:0]        rd_owner_r;

    logic [N_MASTERS-1:0] act_s;
    logic                 sel_vld_s;
    logic [PW-1:0]        cur_s;
    logic [PW-1:0]        scan_s;
    logic                 done_s;

    logic [3:0]           rd_be_s   [N_MASTERS];
    logic [31:0]          rd_addr_s [N_MASTERS];
    logic [3:0]           wr_be_s   [N_MASTERS];
    logic [31:0]          wr_addr_s [N_MASTERS];
    logic [31:0]          wr_data_s [N_MASTERS];

    // Modulo-N_MASTERS increment of a master index
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        if (v == PW'(N_MASTERS - 1)) begin
            r = '0;
        end else begin
            r = v + PW'(1);
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
        assign rd_be_s[gi]   = m_rd_be[4*gi +: 4];
        assign rd_addr_s[gi] = m_rd_addr[32*gi +: 32];
        assign wr_be_s[gi]   = m_wr_be[4*gi +: 4];
        assign wr_addr_s[gi] = m_wr_addr[32*gi +: 32];
        assign wr_data_s[gi] = m_wr_data[32*gi +: 32];
        // Only the owner of last cycle's read grant sees the slave data
        assign m_rd_data[32*gi +: 32] = (rd_owner_vld_r && (rd_owner_r == PW'(gi))) ? s_rd_data : 32'h0000_0000;
    end

    assign act_s = m_rd_req | m_wr_req;

    // Pick the current master: sticky lock first, else first active from rr_ptr
    always_comb begin
        sel_vld_s = 1'b0;
        cur_s     = '0;
        scan_s    = rr_ptr_r;
        if (sel_lock_r && act_s[sel_idx_r]) begin
            sel_vld_s = 1'b1;
            cur_s     = sel_idx_r;
        end else begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (!sel_vld_s && act_s[scan_s]) begin
                    sel_vld_s = 1'b1;
                    cur_s     = scan_s;
                end else begin
                    cur_s = cur_s;
                end
                scan_s = wrap_inc(scan_s);
            end
        end
    end

    // Forward the selected master to the slave and gate its grants
    always_comb begin
        s_rd_req  = 1'b0;
        s_rd_be   = 4'h0;
        s_rd_addr = 32'h0000_0000;
        s_wr_req  = 1'b0;
        s_wr_be   = 4'h0;
        s_wr_addr = 32'h0000_0000;
        s_wr_data = 32'h0000_0000;
        m_rd_gnt  = '0;
        m_wr_gnt  = '0;
        if (sel_vld_s) begin
            s_rd_req        = m_rd_req[cur_s];
            s_rd_be         = rd_be_s[cur_s];
            s_rd_addr       = rd_addr_s[cur_s];
            s_wr_req        = m_wr_req[cur_s];
            s_wr_be         = wr_be_s[cur_s];
            s_wr_addr       = wr_addr_s[cur_s];
            s_wr_data       = wr_data_s[cur_s];
            m_rd_gnt[cur_s] = s_rd_gnt & m_rd_req[cur_s];
            m_wr_gnt[cur_s] = s_wr_gnt & m_wr_req[cur_s];
        end else begin
            s_rd_req = 1'b0;
        end
    end

    // A transaction completes when every request the master raised is granted
    assign done_s = sel_vld_s & (~m_rd_req[cur_s] | s_rd_gnt) & (~m_wr_req[cur_s] | s_wr_gnt);

    // Arbitration pointer, sticky lock and read-return owner
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_r       <= '0;
            sel_lock_r     <= 1'b0;
            sel_idx_r      <= '0;
            rd_owner_vld_r <= 1'b0;
            rd_owner_r     <= '0;
        end else begin
            if (done_s) begin
                rr_ptr_r   <= wrap_inc(cur_s);
                sel_lock_r <= 1'b0;
            end else if (sel_vld_s) begin
                sel_lock_r <= 1'b1;
                sel_idx_r  <= cur_s;
            end else begin
                sel_lock_r <= 1'b0;
            end
            if (s_rd_req && s_rd_gnt) begin
                rd_owner_r     <= cur_s;
                rd_owner_vld_r <= 1'b1;
            end else begin
                rd_owner_vld_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Directed self-checking bench for naive_bus_rr_arbiter with two masters.
module tb_naive_bus_rr_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  m_rd_req;
    logic [7:0]  m_rd_be;
    logic [63:0] m_rd_addr;
    logic [1:0]  m_rd_gnt;
    logic [63:0] m_rd_data;
    logic [1:0]  m_wr_req;
    logic [7:0]  m_wr_be;
    logic [63:0] m_wr_addr;
    logic [63:0] m_wr_data;
    logic [1:0]  m_wr_gnt;
    logic        s_rd_req;
    logic [3:0]  s_rd_be;
    logic [31:0] s_rd_addr;
    logic        s_rd_gnt;
    logic [31:0] s_rd_data;
    logic        s_wr_req;
    logic [3:0]  s_wr_be;
    logic [31:0] s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_wr_gnt;

    int          n_checks;
    int          n_errors;
    logic [31:0] d_val;
    logic [63:0] exp_data;

    naive_bus_rr_arbiter #(.N_MASTERS(2)) dut (
        .clk(clk), .rstn(rstn),
        .m_rd_req(m_rd_req), .m_rd_be(m_rd_be), .m_rd_addr(m_rd_addr),
        .m_rd_gnt(m_rd_gnt), .m_rd_data(m_rd_data),
        .m_wr_req(m_wr_req), .m_wr_be(m_wr_be), .m_wr_addr(m_wr_addr),
        .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
        .s_rd_req(s_rd_req), .s_rd_be(s_rd_be), .s_rd_addr(s_rd_addr),
        .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
        .s_wr_req(s_wr_req), .s_wr_be(s_wr_be), .s_wr_addr(s_wr_addr),
        .s_wr_data(s_wr_data), .s_wr_gnt(s_wr_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m_rd_req  = 2'b00;
        m_wr_req  = 2'b00;
        s_rd_gnt  = 1'b0;
        s_wr_gnt  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        m_rd_be   = 8'hFF;
        m_wr_be   = 8'hFF;
        m_rd_addr = 64'h0;
        m_wr_addr = 64'h0;
        m_wr_data = 64'h0;
        s_rd_data = 32'h0;
        idle();

        // reset state
        @(negedge clk); #1;
        check_eq("rst_s_rd_req", 64'(s_rd_req), 64'h0);
        check_eq("rst_s_wr_req", 64'(s_wr_req), 64'h0);
        check_eq("rst_s_rd_addr", 64'(s_rd_addr), 64'h0);
        check_eq("rst_s_wr_data", 64'(s_wr_data), 64'h0);
        check_eq("rst_gnts", 64'({m_rd_gnt, m_wr_gnt}), 64'h0);
        check_eq("rst_rd_data", m_rd_data, 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        // single read from master 1
        @(negedge clk);
        m_rd_req  = 2'b10;
        m_rd_addr = {32'h0000_1000, 32'h0000_0000};
        s_rd_gnt  = 1'b1;
        #1;
        check_eq("m1_rd_gnt", 64'(m_rd_gnt), 64'h2);
        check_eq("m1_s_rd_addr", 64'(s_rd_addr), 64'h1000);
        check_eq("m1_s_rd_be", 64'(s_rd_be), 64'hF);
        @(negedge clk);
        idle();
        s_rd_data = 32'hDEAD_BEEF;
        #1;
        check_eq("m1_rd_data", m_rd_data, {32'hDEAD_BEEF, 32'h0});
        check_eq("nosel_s_rd_addr", 64'(s_rd_addr), 64'h0);
        @(negedge clk); #1;
        check_eq("m1_rd_data_gone", m_rd_data, 64'h0);

        // both masters read continuously: grants alternate, data routed per slot
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_rd_req  = 2'b11;
            m_rd_addr = {32'h0000_0200, 32'h0000_0100};
            s_rd_gnt  = 1'b1;
            d_val     = 32'hA000_0000 + 32'(k);
            s_rd_data = d_val;
            #1;
            check_eq("rr_gnt", 64'(m_rd_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
            check_eq("rr_addr", 64'(s_rd_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
            if (k == 0) exp_data = 64'h0;
            else if (k % 2 == 1) exp_data = {32'h0, d_val};
            else exp_data = {d_val, 32'h0};
            check_eq("rr_data", m_rd_data, exp_data);
        end
        @(negedge clk);
        idle();
        s_rd_data = 32'hA000_0004;
        #1;
        check_eq("rr_data_last", m_rd_data, {32'hA000_0004, 32'h0});

        // master 0 write completes, moving rr_ptr to 1
        @(negedge clk);
        m_wr_req  = 2'b01;
        m_wr_addr = {32'h0000_2000, 32'h0000_3000};
        m_wr_data = {32'h0000_55AA, 32'h0000_1111};
        s_wr_gnt  = 1'b1;
        #1;
        check_eq("w0_wr_gnt", 64'(m_wr_gnt), 64'h1);

        // master 1 write stalled for 3 cycles while master 0 waits
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_wr_req = 2'b11;
            s_wr_gnt = (k == 3) ? 1'b1 : 1'b0;
            #1;
            check_eq("stall_wr_addr", 64'(s_wr_addr), 64'h2000);
            check_eq("stall_wr_data", 64'(s_wr_data), 64'h55AA);
            check_eq("stall_wr_gnt", 64'(m_wr_gnt), (k == 3) ? 64'h2 : 64'h0);
        end
        @(negedge clk);
        m_wr_req = 2'b11;
        s_wr_gnt = 1'b1;
        #1;
        check_eq("after_stall_addr", 64'(s_wr_addr), 64'h3000);
        check_eq("after_stall_gnt", 64'(m_wr_gnt), 64'h1);
        @(negedge clk);
        idle();
        #1;
        check_eq("idle_s_wr_req", 64'(s_wr_req), 64'h0);

        // master 0 rd+wr, only write granted: stays locked
        @(negedge clk);
        m_rd_req  = 2'b01;
        m_wr_req  = 2'b01;
        m_rd_addr = {32'h0000_0500, 32'h0000_0400};
        s_rd_gnt  = 1'b0;
        s_wr_gnt  = 1'b1;
        #1;
        check_eq("rw_both_fwd", 64'({s_rd_req, s_wr_req}), 64'h3);
        check_eq("rw_wr_gnt", 64'(m_wr_gnt), 64'h1);
        check_eq("rw_rd_gnt", 64'(m_rd_gnt), 64'h0);
        @(negedge clk);
        m_rd_req = 2'b11;
        m_wr_req = 2'b00;
        s_rd_gnt = 1'b1;
        s_wr_gnt = 1'b0;
        #1;
        check_eq("lock_rd_gnt", 64'(m_rd_gnt), 64'h1);
        check_eq("lock_rd_addr", 64'(s_rd_addr), 64'h400);
        @(negedge clk);
        s_rd_data = 32'hCAFE_F00D;
        #1;
        check_eq("adv_rd_gnt", 64'(m_rd_gnt), 64'h2);
        check_eq("adv_rd_data", m_rd_data, {32'h0, 32'hCAFE_F00D});
        @(negedge clk);
        m_rd_req  = 2'b01;
        s_rd_data = 32'h0BAD_F00D;
        #1;
        check_eq("m0_rd_gnt", 64'(m_rd_gnt), 64'h1);
        check_eq("m0_prev_data", m_rd_data, {32'h0BAD_F00D, 32'h0});

        // async reset right after a read grant to master 0
        @(negedge clk);
        rstn = 1'b0;
        idle();
        s_rd_data = 32'h1234_5678;
        #1;
        check_eq("rst_drop_data", m_rd_data, 64'h0);
        check_eq("rst_mid_gnt", 64'(m_rd_gnt), 64'h0);
        @(negedge clk);
        rstn     = 1'b1;
        m_rd_req = 2'b11;
        s_rd_gnt = 1'b1;
        #1;
        check_eq("rst_rr_ptr0", 64'(m_rd_gnt), 64'h1);
        @(negedge clk);
        idle();
        s_rd_data = 32'h0000_0077;
        #1;
        check_eq("rst_then_data", m_rd_data, {32'h0, 32'h0000_0077});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
